// File: rtl/div_pkg.sv
// ----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential divider: FSM state encoding, operand
// width and the number of shift-subtract iterations.
// ----------------------------------------------------------------------------
package div_pkg;

   localparam int DIV_WIDTH = 32;
   localparam int DIV_ITER  = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIVIDE = 2'd1,
      FIX    = 2'd2,
      DONE   = 2'd3
   } div_state_t;

endpackage

// File: rtl/div_abs_neg.sv
// ----------------------------------------------------------------------------
// div_abs_neg
// Combinational two's-complement conditional negate. It serves as the
// absolute-value stage for the operands (i_neg = operand sign) and as the
// sign-correction stage for the results.
//   i_val : value in
//   i_neg : 1 = output the two's-complement negation of i_val
//   o_val : i_val or -i_val (wraps, so -0x80000000 = 0x80000000)
// ----------------------------------------------------------------------------
module div_abs_neg
   import div_pkg::*;
#(
   parameter int W = DIV_WIDTH
) (
   input  logic [W-1:0] i_val,
   input  logic         i_neg,
   output logic [W-1:0] o_val
);

   assign o_val = i_neg ? (~i_val + {{(W-1){1'b0}}, 1'b1}) : i_val;

endmodule

// File: rtl/seq_divider.sv
// ----------------------------------------------------------------------------
// seq_divider
// Multi-cycle restoring divider with MIPS div semantics (truncate toward
// zero, remainder takes the dividend's sign). 32 iterations plus a sign-fix
// cycle; div_end pulses for one cycle in DONE.
//   clk, rst     : clock, synchronous active-high reset
//   div_start    : request, sampled only in IDLE
//   dividend     : rs operand, sampled at the accepting edge
//   divisor      : rt operand, sampled at the accepting edge
//   div_unsigned : (only with SEQ_DIV_UNSIGNED_EN) unsigned division request
//   div_end      : one-cycle completion pulse
//   hi / lo      : remainder / quotient, held until the next result
//   div_by_zero  : last accepted request had divisor 0
// Optional feature macro: SEQ_DIV_UNSIGNED_EN (adds div_unsigned port).
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for div_start
// DIVIDE | one shift-subtract step per cycle, 32 cycles
// FIX    | sign-correct quotient/remainder, load hi/lo
// DONE   | div_end high for this one cycle, then back to IDLE
// ----------------------------------------------------------------------------
module seq_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             div_start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIV_UNSIGNED_EN
   input  logic             div_unsigned,
`endif
   output logic             div_end,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);

   localparam logic [5:0] CNT_LAST = 6'(DIV_ITER - 1);

   div_state_t       r_state;
   logic [5:0]       r_cnt;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_dvs;
   logic             r_neg_q;
   logic             r_neg_r;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic             r_dbz;
   logic             r_div_end;

   logic             w_uns;
   logic             w_a_neg;
   logic             w_b_neg;
   logic [WIDTH-1:0] w_a_abs;
   logic [WIDTH-1:0] w_b_abs;
   logic [WIDTH-1:0] w_q_fix;
   logic [WIDTH-1:0] w_r_fix;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH-1:0] w_sub;
   logic             w_ge;

`ifdef SEQ_DIV_UNSIGNED_EN
   assign w_uns = div_unsigned;
`else
   assign w_uns = 1'b0;
`endif

   // Unsigned requests bypass the absolute-value stage and the sign fix.
   assign w_a_neg = ~w_uns & dividend[WIDTH-1];
   assign w_b_neg = ~w_uns & divisor[WIDTH-1];

   div_abs_neg #(.W(WIDTH)) u_abs_a (.i_val(dividend), .i_neg(w_a_neg), .o_val(w_a_abs));
   div_abs_neg #(.W(WIDTH)) u_abs_b (.i_val(divisor),  .i_neg(w_b_neg), .o_val(w_b_abs));
   div_abs_neg #(.W(WIDTH)) u_fix_q (.i_val(r_quo),    .i_neg(r_neg_q), .o_val(w_q_fix));
   div_abs_neg #(.W(WIDTH)) u_fix_r (.i_val(r_rem),    .i_neg(r_neg_r), .o_val(w_r_fix));

   // Shifted partial remainder needs one extra bit; when it is >= divisor the
   // difference is below the divisor, so a WIDTH-bit subtract is exact.
   assign w_shift = {r_rem, r_quo[WIDTH-1]};
   assign w_ge    = (w_shift >= {1'b0, r_dvs});
   assign w_sub   = w_shift[WIDTH-1:0] - r_dvs;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_rem     <= '0;
         r_quo     <= '0;
         r_dvs     <= '0;
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_dbz     <= 1'b0;
         r_div_end <= 1'b0;
      end else begin
         r_div_end <= 1'b0;
         case (r_state)
            IDLE: begin
               if (div_start) begin
                  if (divisor == '0) begin
                     r_dbz     <= 1'b1;
                     r_div_end <= 1'b1;
                     r_state   <= DONE;
                  end else begin
                     r_quo   <= w_a_abs;
                     r_dvs   <= w_b_abs;
                     r_rem   <= '0;
                     r_cnt   <= '0;
                     r_neg_q <= w_a_neg ^ w_b_neg;
                     r_neg_r <= w_a_neg;
                     r_dbz   <= 1'b0;
                     r_state <= DIVIDE;
                  end
               end
            end
            DIVIDE: begin
               // Dividend bits shift out of r_quo as quotient bits shift in.
               if (w_ge) begin
                  r_rem <= w_sub;
                  r_quo <= {r_quo[WIDTH-2:0], 1'b1};
               end else begin
                  r_rem <= w_shift[WIDTH-1:0];
                  r_quo <= {r_quo[WIDTH-2:0], 1'b0};
               end
               if (r_cnt == CNT_LAST) begin
                  r_state <= FIX;
               end else begin
                  r_cnt <= r_cnt + 6'd1;
               end
            end
            FIX: begin
               r_hi      <= w_r_fix;
               r_lo      <= w_q_fix;
               r_div_end <= 1'b1;
               r_state   <= DONE;
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign div_end     = r_div_end;
   assign hi          = r_hi;
   assign lo          = r_lo;
   assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// ----------------------------------------------------------------------------
// tb_seq_divider
// Self-checking bench for seq_divider. Expected results come from a reference
// model using 64-bit integer division/modulo on sign- or zero-extended
// operands, plus directed constant checks.
// ----------------------------------------------------------------------------
module tb_seq_divider;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        div_start = 1'b0;
   logic [31:0] dividend = '0;
   logic [31:0] divisor = '0;
`ifdef SEQ_DIV_UNSIGNED_EN
   logic        div_unsigned = 1'b0;
`endif
   logic        div_end;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        div_by_zero;

   int n_total = 0;
   int n_pass  = 0;

   logic [31:0] m_hi  = '0;
   logic [31:0] m_lo  = '0;
   logic        m_dbz = 1'b0;

   seq_divider #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .div_start   (div_start),
      .dividend    (dividend),
      .divisor     (divisor),
`ifdef SEQ_DIV_UNSIGNED_EN
      .div_unsigned(div_unsigned),
`endif
      .div_end     (div_end),
      .hi          (hi),
      .lo          (lo),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model: integer arithmetic, truncating toward zero.
   task automatic model_div(input logic [31:0] a, input logic [31:0] b, input bit uns);
      longint sa, sb, q, r;
      if (b == 32'd0) begin
         m_dbz = 1'b1;
      end else begin
         sa = uns ? longint'(a) : longint'($signed(a));
         sb = uns ? longint'(b) : longint'($signed(b));
         q = sa / sb;
         r = sa % sb;
         m_lo  = q[31:0];
         m_hi  = r[31:0];
         m_dbz = 1'b0;
      end
   endtask

   // Issue one pulsed request and watch div_end for ncyc samples.
   // Sample k is taken 1 time unit after the (k-1)-th edge following accept.
   task automatic do_div(input logic [31:0] a, input logic [31:0] b, input bit uns,
                         input int ncyc, output int first, output int pulses);
      dividend  = a;
      divisor   = b;
`ifdef SEQ_DIV_UNSIGNED_EN
      div_unsigned = uns;
`endif
      div_start = 1'b1;
      model_div(a, b, uns);
      @(posedge clk); #1;
      div_start = 1'b0;
      first  = 0;
      pulses = 0;
      for (int k = 1; k <= ncyc; k++) begin
         if (div_end === 1'b1) begin
            pulses++;
            if (first == 0) first = k;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      int f, p;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_total++; if (div_end !== 1'b0)  $display("FAIL rst_div_end got %b want 0", div_end); else n_pass++;
      n_total++; if (hi !== 32'd0)      $display("FAIL rst_hi got %h want 0", hi); else n_pass++;
      n_total++; if (lo !== 32'd0)      $display("FAIL rst_lo got %h want 0", lo); else n_pass++;
      n_total++; if (div_by_zero !== 1'b0) $display("FAIL rst_dbz got %b want 0", div_by_zero); else n_pass++;
      // Start accepted on the first edge after rst drops.
      rst = 1'b0;
      do_div(32'd100, 32'd7, 1'b0, 40, f, p);
      n_total++; if (f !== 34) $display("FAIL first_end_cycle got %0d want 34", f); else n_pass++;
      n_total++; if (p !== 1)  $display("FAIL first_end_pulses got %0d want 1", p); else n_pass++;
      n_total++; if (lo !== 32'h0000000E) $display("FAIL d100_7_lo got %h want 0000000e", lo); else n_pass++;
      n_total++; if (hi !== 32'h00000002) $display("FAIL d100_7_hi got %h want 00000002", hi); else n_pass++;
   endtask

   task automatic test_directed();
      int f, p;
      do_div(32'hFFFFFF9C, 32'd7, 1'b0, 40, f, p);
      n_total++; if (lo !== 32'hFFFFFFF2) $display("FAIL m100_7_lo got %h want fffffff2", lo); else n_pass++;
      n_total++; if (hi !== 32'hFFFFFFFE) $display("FAIL m100_7_hi got %h want fffffffe", hi); else n_pass++;
      do_div(32'd100, 32'd7, 1'b0, 40, f, p);
      do_div(32'd5, 32'd0, 1'b0, 40, f, p);
      n_total++; if (f !== 1) $display("FAIL dz_end_cycle got %0d want 1", f); else n_pass++;
      n_total++; if (p !== 1) $display("FAIL dz_pulses got %0d want 1", p); else n_pass++;
      n_total++; if (div_by_zero !== 1'b1) $display("FAIL dz_flag got %b want 1", div_by_zero); else n_pass++;
      n_total++; if (hi !== 32'd2)  $display("FAIL dz_hi_hold got %h want 00000002", hi); else n_pass++;
      n_total++; if (lo !== 32'd14) $display("FAIL dz_lo_hold got %h want 0000000e", lo); else n_pass++;
      do_div(32'h80000000, 32'hFFFFFFFF, 1'b0, 40, f, p);
      n_total++; if (f !== 34) $display("FAIL ovf_end_cycle got %0d want 34", f); else n_pass++;
      n_total++; if (lo !== 32'h80000000) $display("FAIL ovf_lo got %h want 80000000", lo); else n_pass++;
      n_total++; if (hi !== 32'h00000000) $display("FAIL ovf_hi got %h want 00000000", hi); else n_pass++;
      n_total++; if (div_by_zero !== 1'b0) $display("FAIL ovf_dbz got %b want 0", div_by_zero); else n_pass++;
   endtask

   task automatic test_random();
      int f, p;
      logic [31:0] a, b;
      for (int i = 0; i < 30; i++) begin
         case ($urandom_range(0, 3))
            0: a = $urandom_range(0, 255);
            1: a = 32'h80000000;
            default: a = $urandom;
         endcase
         if ($urandom_range(0, 2) == 0) b = 32'($urandom_range(0, 9)) - 32'd4;
         else b = $urandom;
         do_div(a, b, 1'b0, 40, f, p);
         n_total++; if (f !== ((b == 0) ? 1 : 34)) $display("FAIL rnd_end_cycle a=%h b=%h got %0d", a, b, f); else n_pass++;
         n_total++; if (p !== 1) $display("FAIL rnd_pulses a=%h b=%h got %0d want 1", a, b, p); else n_pass++;
         n_total++; if (lo !== m_lo) $display("FAIL rnd_lo a=%h b=%h got %h want %h", a, b, lo, m_lo); else n_pass++;
         n_total++; if (hi !== m_hi) $display("FAIL rnd_hi a=%h b=%h got %h want %h", a, b, hi, m_hi); else n_pass++;
         n_total++; if (div_by_zero !== m_dbz) $display("FAIL rnd_dbz a=%h b=%h got %b want %b", a, b, div_by_zero, m_dbz); else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      int f, p;
      do_div(32'd100, 32'd7, 1'b0, 40, f, p);
      dividend  = 32'd50;
      divisor   = 32'd7;
      div_start = 1'b1;
      @(posedge clk); #1;
      div_start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      m_hi = '0; m_lo = '0; m_dbz = 1'b0;
      n_total++; if (hi !== 32'd0) $display("FAIL midrst_hi got %h want 0", hi); else n_pass++;
      n_total++; if (lo !== 32'd0) $display("FAIL midrst_lo got %h want 0", lo); else n_pass++;
      n_total++; if (div_by_zero !== 1'b0) $display("FAIL midrst_dbz got %b want 0", div_by_zero); else n_pass++;
      p = 0;
      for (int k = 0; k < 40; k++) begin
         if (div_end !== 1'b0) p++;
         @(posedge clk); #1;
      end
      n_total++; if (p !== 0) $display("FAIL midrst_no_end got %0d pulses want 0", p); else n_pass++;
      do_div(32'd9, 32'd3, 1'b0, 40, f, p);
      n_total++; if (f !== 34) $display("FAIL post_rst_end got %0d want 34", f); else n_pass++;
      n_total++; if (lo !== 32'd3) $display("FAIL post_rst_lo got %h want 00000003", lo); else n_pass++;
      n_total++; if (hi !== 32'd0) $display("FAIL post_rst_hi got %h want 0", hi); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int first, second, p;
      logic [31:0] lo1, hi1;
      // Second request mid-DIVIDE must be ignored.
      dividend  = 32'd1000;
      divisor   = 32'd3;
      div_start = 1'b1;
      @(posedge clk); #1;
      div_start = 1'b0;
      first = 0; p = 0;
      for (int k = 1; k <= 45; k++) begin
         if (div_end === 1'b1) begin
            p++;
            if (first == 0) first = k;
         end
         if (k == 5) begin
            dividend = 32'd7; divisor = 32'd1; div_start = 1'b1;
         end else begin
            div_start = 1'b0;
         end
         @(posedge clk); #1;
      end
      n_total++; if (first !== 34) $display("FAIL b2b_end_cycle got %0d want 34", first); else n_pass++;
      n_total++; if (p !== 1) $display("FAIL b2b_pulses got %0d want 1", p); else n_pass++;
      n_total++; if (lo !== 32'd333) $display("FAIL b2b_lo got %h want 0000014d", lo); else n_pass++;
      n_total++; if (hi !== 32'd1) $display("FAIL b2b_hi got %h want 00000001", hi); else n_pass++;
      // Held start: restart only after returning to IDLE.
      dividend  = 32'd20;
      divisor   = 32'd6;
      div_start = 1'b1;
      @(posedge clk); #1;
      dividend = 32'd21;
      first = 0; second = 0; p = 0; lo1 = '0; hi1 = '0;
      for (int k = 1; k <= 70; k++) begin
         if (div_end === 1'b1) begin
            p++;
            if (first == 0) begin
               first = k; lo1 = lo; hi1 = hi;
            end else if (second == 0) begin
               second = k;
            end
         end
         @(posedge clk); #1;
      end
      div_start = 1'b0;
      n_total++; if (first !== 34)  $display("FAIL held_first got %0d want 34", first); else n_pass++;
      n_total++; if (second !== 69) $display("FAIL held_second got %0d want 69", second); else n_pass++;
      n_total++; if (lo1 !== 32'd3) $display("FAIL held_lo1 got %h want 00000003", lo1); else n_pass++;
      n_total++; if (hi1 !== 32'd2) $display("FAIL held_hi1 got %h want 00000002", hi1); else n_pass++;
      n_total++; if (lo !== 32'd3) $display("FAIL held_lo2 got %h want 00000003", lo); else n_pass++;
      n_total++; if (hi !== 32'd3) $display("FAIL held_hi2 got %h want 00000003", hi); else n_pass++;
      // A third request was accepted while start was held; let it drain.
      repeat (40) @(posedge clk);
      #1;
      m_lo = 32'd3; m_hi = 32'd3; m_dbz = 1'b0;
   endtask

`ifdef SEQ_DIV_UNSIGNED_EN
   task automatic test_unsigned();
      int f, p;
      logic [31:0] a, b;
      do_div(32'hFFFFFFFF, 32'd2, 1'b1, 40, f, p);
      n_total++; if (lo !== 32'h7FFFFFFF) $display("FAIL uns_lo got %h want 7fffffff", lo); else n_pass++;
      n_total++; if (hi !== 32'd1) $display("FAIL uns_hi got %h want 00000001", hi); else n_pass++;
      do_div(32'hFFFFFFFF, 32'd2, 1'b0, 40, f, p);
      n_total++; if (lo !== 32'd0) $display("FAIL sgn_m1_lo got %h want 0", lo); else n_pass++;
      n_total++; if (hi !== 32'hFFFFFFFF) $display("FAIL sgn_m1_hi got %h want ffffffff", hi); else n_pass++;
      for (int i = 0; i < 10; i++) begin
         a = $urandom;
         b = $urandom | 32'd1;
         do_div(a, b, 1'b1, 40, f, p);
         n_total++; if (lo !== m_lo) $display("FAIL uns_rnd_lo a=%h b=%h got %h want %h", a, b, lo, m_lo); else n_pass++;
         n_total++; if (hi !== m_hi) $display("FAIL uns_rnd_hi a=%h b=%h got %h want %h", a, b, hi, m_hi); else n_pass++;
      end
      div_unsigned = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_reset_mid();
      test_back_to_back();
`ifdef SEQ_DIV_UNSIGNED_EN
      test_unsigned();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
